// File: rtl/interrupt_controller.sv
// Multi-channel interrupt controller: synchronised level/edge latching, mask, fixed priority (lowest index wins).
// Latency: 4 edges from the first edge that samples irq_in to irq_req. Holds a single request until ack, then no new request until done.
module interrupt_controller #(
    parameter int                 NUM_CH     = 4,
    parameter int                 DATA_W     = 8,
    parameter logic [DATA_W-1:0]  VEC_BASE   = 8'hF0,
    parameter int                 VEC_STRIDE = 4,
    localparam int                CH_W       = $clog2(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NUM_CH-1:0] irq_in_i,
    input  logic              mask_wr_i,
    input  logic [NUM_CH-1:0] mask_data_i,
    input  logic              mode_wr_i,
    input  logic [NUM_CH-1:0] mode_data_i,
    input  logic              irq_ack_i,
    input  logic              irq_done_i,
    output logic              irq_req_o,
    output logic [DATA_W-1:0] irq_vector_o,
    output logic [CH_W-1:0]   active_ch_o,
    output logic              busy_o,
    output logic [NUM_CH-1:0] pending_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   s1_q, s2_q, s3_q;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [NUM_CH-1:0]   mask_q, mode_q;
    logic [DATA_W-1:0]   vec_q, vec_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [NUM_CH-1:0]   eligible;
    logic [CH_W-1:0]     winner;
    logic [DATA_W-1:0]   vec_calc;
    logic                ack_take;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            mode_q    <= '0;
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            ch_q      <= '0;
        end else begin
            s1_q      <= irq_in_i;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pending_q <= pending_d;
            state_q   <= state_d;
            vec_q     <= vec_d;
            ch_q      <= ch_d;
            if (mask_wr_i) mask_q <= mask_data_i;
            if (mode_wr_i) mode_q <= mode_data_i;
        end
    end

    assign ack_take = (state_q == ST_REQ) && irq_ack_i;

    // Edge channels hold until acknowledged; a new rising edge wins over a same-cycle ack.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mode_q[i]) begin
                if (ack_take && (ch_q == CH_W'(i))) pending_d[i] = 1'b0;
                if (s2_q[i] && !s3_q[i])            pending_d[i] = 1'b1;
            end else begin
                pending_d[i] = s2_q[i];
            end
        end
    end

    assign eligible = pending_q & ~mask_q;

    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) winner = CH_W'(i);
        end
    end

    assign vec_calc = VEC_BASE + DATA_W'(VEC_STRIDE) * DATA_W'(winner);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    ch_d    = winner;
                    vec_d   = vec_calc;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack_i) state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (irq_done_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign irq_req_o    = (state_q == ST_REQ);
    assign busy_o       = (state_q != ST_IDLE);
    assign irq_vector_o = vec_q;
    assign active_ch_o  = ch_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: default instance plus a second instance with a wrapping vector base.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in, mask_data, mode_data;
    logic       mask_wr, mode_wr, irq_ack, irq_done;
    logic       irq_req, busy;
    logic [7:0] irq_vector;
    logic [1:0] active_ch;
    logic [3:0] pending;

    logic [3:0] w_irq_in, w_mask_data;
    logic       w_mask_wr;
    logic       w_irq_req, w_busy;
    logic [7:0] w_irq_vector;
    logic [1:0] w_active_ch;
    logic [3:0] w_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    interrupt_controller u_dut (
        .clk_i(clk), .reset_i(reset), .irq_in_i(irq_in),
        .mask_wr_i(mask_wr), .mask_data_i(mask_data),
        .mode_wr_i(mode_wr), .mode_data_i(mode_data),
        .irq_ack_i(irq_ack), .irq_done_i(irq_done),
        .irq_req_o(irq_req), .irq_vector_o(irq_vector),
        .active_ch_o(active_ch), .busy_o(busy), .pending_o(pending)
    );

    interrupt_controller #(.NUM_CH(4), .DATA_W(8), .VEC_BASE(8'hFE), .VEC_STRIDE(4)) u_wrap (
        .clk_i(clk), .reset_i(reset), .irq_in_i(w_irq_in),
        .mask_wr_i(w_mask_wr), .mask_data_i(w_mask_data),
        .mode_wr_i(1'b0), .mode_data_i(4'b0000),
        .irq_ack_i(1'b0), .irq_done_i(1'b0),
        .irq_req_o(w_irq_req), .irq_vector_o(w_irq_vector),
        .active_ch_o(w_active_ch), .busy_o(w_busy), .pending_o(w_pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; mask_wr = 0; mask_data = '0; mode_wr = 0; mode_data = '0;
        irq_ack = 0; irq_done = 0; w_irq_in = '0; w_mask_wr = 0; w_mask_data = '0;
        #1;
        check("rst_req",     32'(irq_req),    0);
        check("rst_busy",    32'(busy),       0);
        check("rst_pending", 32'(pending),    0);
        check("rst_vector",  32'(irq_vector), 0);
        check("rst_ch",      32'(active_ch),  0);
        step(2);
        reset = 1'b0;

        // Unmask all, level mode; single channel latency and handshake
        mask_wr = 1; mask_data = 4'b0000; mode_wr = 1; mode_data = 4'b0000;
        step(1);
        mask_wr = 0; mode_wr = 0;
        irq_in = 4'b0100;
        step(3);
        check("lat_edge3_req", 32'(irq_req), 0);
        step(1);
        check("lat_edge4_req", 32'(irq_req),    1);
        check("t1_vector",     32'(irq_vector), 'hF8);
        check("t1_ch",         32'(active_ch),  2);
        check("t1_busy",       32'(busy),       1);
        irq_in = 4'b0000;
        irq_ack = 1; step(1); irq_ack = 0;
        check("t1_ack_req",  32'(irq_req), 0);
        check("t1_ack_busy", 32'(busy),    1);
        step(3);
        check("t1_svc_busy", 32'(busy),    1);
        check("t1_svc_req",  32'(irq_req), 0);
        irq_done = 1; step(1); irq_done = 0;
        check("t1_done_busy", 32'(busy), 0);
        step(2);
        check("t1_idle_req",     32'(irq_req), 0);
        check("t1_idle_pending", 32'(pending), 0);

        // Two level channels: lowest index first, then the remaining one
        irq_in = 4'b1010;
        step(4);
        check("t2_first_req", 32'(irq_req),    1);
        check("t2_first_vec", 32'(irq_vector), 'hF4);
        check("t2_first_ch",  32'(active_ch),  1);
        irq_in = 4'b1000;
        irq_ack = 1; step(1); irq_ack = 0;
        step(3);
        irq_done = 1; step(1); irq_done = 0;
        check("t2_gap_req",  32'(irq_req), 0);
        check("t2_gap_busy", 32'(busy),    0);
        step(1);
        check("t2_second_req", 32'(irq_req),    1);
        check("t2_second_vec", 32'(irq_vector), 'hFC);
        check("t2_second_ch",  32'(active_ch),  3);
        irq_in = 4'b0000;
        irq_ack = 1; irq_done = 1; step(1); irq_ack = 0; irq_done = 0;
        check("t2_ackdone_busy", 32'(busy),    1);
        check("t2_ackdone_req",  32'(irq_req), 0);
        step(3);
        irq_done = 1; step(1); irq_done = 0;
        step(2);
        check("t2_end_busy", 32'(busy), 0);

        // Edge channel 0 latched while channel 2 is in service
        mode_wr = 1; mode_data = 4'b0001; irq_in = 4'b0100;
        step(1);
        mode_wr = 0;
        step(3);
        check("t3_ch2_req", 32'(irq_req),   1);
        check("t3_ch2_ch",  32'(active_ch), 2);
        irq_ack = 1; step(1); irq_ack = 0;
        irq_in = 4'b0001;
        step(1);
        irq_in = 4'b0000;
        step(4);
        check("t3_held_pending", 32'(pending), 4'b0001);
        check("t3_held_req",     32'(irq_req), 0);
        check("t3_held_busy",    32'(busy),    1);
        irq_done = 1; step(1); irq_done = 0;
        check("t3_done_req", 32'(irq_req), 0);
        step(1);
        check("t3_ch0_req",     32'(irq_req),    1);
        check("t3_ch0_vec",     32'(irq_vector), 'hF0);
        check("t3_ch0_ch",      32'(active_ch),  0);
        check("t3_ch0_pending", 32'(pending),    4'b0001);
        irq_ack = 1; step(1); irq_ack = 0;
        check("t3_ack_pending", 32'(pending), 0);
        irq_done = 1; step(1); irq_done = 0;
        step(2);
        check("t3_end_req", 32'(irq_req), 0);

        // Masking and re-masking during a request
        mode_wr = 1; mode_data = 4'b0000; step(1); mode_wr = 0;
        mask_wr = 1; mask_data = 4'b0010; step(1); mask_wr = 0;
        irq_in = 4'b0010;
        step(6);
        check("t4_masked_req",     32'(irq_req), 0);
        check("t4_masked_pending", 32'(pending), 4'b0010);
        mask_wr = 1; mask_data = 4'b0000; step(1); mask_wr = 0;
        check("t4_unmask_land_req", 32'(irq_req), 0);
        step(1);
        check("t4_unmask_req", 32'(irq_req),    1);
        check("t4_unmask_vec", 32'(irq_vector), 'hF4);
        mask_wr = 1; mask_data = 4'b1111; step(1); mask_wr = 0;
        step(2);
        check("t4_remask_req", 32'(irq_req), 1);
        irq_in = 4'b0000;
        step(3);
        check("t4_drop_req", 32'(irq_req),   1);
        check("t4_drop_ch",  32'(active_ch), 1);
        irq_ack = 1; step(1); irq_ack = 0;
        check("t4_ack_req", 32'(irq_req), 0);
        irq_done = 1; step(1); irq_done = 0;
        step(2);
        check("t4_end_busy", 32'(busy), 0);

        // Asynchronous reset while a request is outstanding
        mask_wr = 1; mask_data = 4'b0000; step(1); mask_wr = 0;
        irq_in = 4'b0100;
        step(4);
        check("t6_pre_req", 32'(irq_req), 1);
        reset = 1'b1;
        #1;
        check("t6_async_req",     32'(irq_req),    0);
        check("t6_async_busy",    32'(busy),       0);
        check("t6_async_pending", 32'(pending),    0);
        check("t6_async_vec",     32'(irq_vector), 0);
        step(1);
        reset = 1'b0;
        step(8);
        check("t6_post_req",     32'(irq_req), 0);
        check("t6_post_busy",    32'(busy),    0);
        check("t6_post_pending", 32'(pending), 4'b0100);

        // Vector address wraps modulo 2^DATA_W
        w_mask_wr = 1; w_mask_data = 4'b0000; step(1); w_mask_wr = 0;
        w_irq_in = 4'b0010;
        step(4);
        check("t5_wrap_req", 32'(w_irq_req),    1);
        check("t5_wrap_vec", 32'(w_irq_vector), 'h02);
        check("t5_wrap_ch",  32'(w_active_ch),  1);
        check("t5_wrap_busy", 32'(w_busy),      1);
        check("t5_wrap_pending", 32'(w_pending), 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
